// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response channel plus
// the decoder-facing instruction channel and the ALU redirect inputs.
interface inst_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvld;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        inst_vld;
   logic [31:0] inst_pc;
   logic        dec_freeze;
   logic        alu_flush;
   logic [31:0] flush_pc;

   // Fetch unit side
   modport master (
      output imem_req, imem_addr, inst, inst_vld, inst_pc,
      input  imem_gnt, imem_rvld, imem_rdata, dec_freeze, alu_flush, flush_pc
   );

   // Memory / decoder / ALU side
   modport slave (
      input  imem_req, imem_addr, inst, inst_vld, inst_pc,
      output imem_gnt, imem_rvld, imem_rdata, dec_freeze, alu_flush, flush_pc
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, tracks up to two
// outstanding requests, buffers returned words in a 2-entry {pc, inst} FIFO
// for the decoder, and redirects on ALU flush while discarding stale data.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              CLK,
   input  logic              RSTN,
   inst_fetch_unit_if.master bus
);

   // Control state
   logic [31:0] fpc_q, fpc_d;
   logic [1:0]  out_cnt_q, out_cnt_d;
   logic [1:0]  drop_cnt_q, drop_cnt_d;
   logic [1:0]  fifo_cnt_q, fifo_cnt_d;
   logic        fifo_rd_q, fifo_rd_d;
   logic        fifo_wr_q, fifo_wr_d;
   logic        tag_rd_q, tag_rd_d;
   logic        tag_wr_q, tag_wr_d;

   // Data storage: in-order PC tags of outstanding requests and the FIFO
   logic [31:0] tag_q       [2];
   logic [31:0] tag_d       [2];
   logic [31:0] fifo_pc_q   [2];
   logic [31:0] fifo_pc_d   [2];
   logic [31:0] fifo_inst_q [2];
   logic [31:0] fifo_inst_d [2];

   logic        inst_vld;
   logic        pop;
   logic        req;
   logic        grant;
   logic        drop;
   logic        keep;
   logic [2:0]  occ;
   logic [31:0] flush_tgt;

   // Redirect target with the byte offset forced to zero
   assign flush_tgt = bus.flush_pc & 32'hFFFF_FFFC;

   assign inst_vld = (fifo_cnt_q != 2'd0);
   assign pop      = inst_vld & ~bus.dec_freeze & ~bus.alu_flush;

   // Slots already claimed by in-flight requests and buffered words; a slot
   // freed by this cycle's pop can be refilled immediately (dec_freeze path).
   assign occ   = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q} - {2'b00, pop};
   assign req   = RSTN & ~bus.alu_flush & (occ < 3'd2);
   assign grant = req & bus.imem_gnt;

   // A response is discarded if it belongs to a flushed fetch stream
   assign drop = bus.imem_rvld & (bus.alu_flush | (drop_cnt_q != 2'd0));
   assign keep = bus.imem_rvld & ~drop;

   assign bus.imem_req  = req;
   assign bus.imem_addr = fpc_q;
   assign bus.inst_vld  = inst_vld;
   assign bus.inst      = inst_vld ? fifo_inst_q[fifo_rd_q] : 32'd0;
   assign bus.inst_pc   = inst_vld ? fifo_pc_q[fifo_rd_q]   : 32'd0;

   // Next-state computation for fetch PC, counters, tag queue and FIFO
   always_comb begin
      fpc_d       = fpc_q;
      out_cnt_d   = out_cnt_q + {1'b0, grant} - {1'b0, bus.imem_rvld};
      drop_cnt_d  = drop_cnt_q;
      fifo_cnt_d  = fifo_cnt_q + {1'b0, keep} - {1'b0, pop};
      fifo_rd_d   = fifo_rd_q ^ pop;
      fifo_wr_d   = fifo_wr_q ^ keep;
      tag_rd_d    = tag_rd_q ^ bus.imem_rvld;
      tag_wr_d    = tag_wr_q ^ grant;
      tag_d       = tag_q;
      fifo_pc_d   = fifo_pc_q;
      fifo_inst_d = fifo_inst_q;

      if (grant) begin
         fpc_d           = fpc_q + 32'd4;
         tag_d[tag_wr_q] = fpc_q;
      end

      if (keep) begin
         fifo_pc_d[fifo_wr_q]   = tag_q[tag_rd_q];
         fifo_inst_d[fifo_wr_q] = bus.imem_rdata;
      end

      if (bus.imem_rvld && (drop_cnt_q != 2'd0)) begin
         drop_cnt_d = drop_cnt_q - 2'd1;
      end

      // Redirect: empty the FIFO and mark every request still in flight
      // after this cycle as stale. Tag pointers keep running so the queue
      // stays aligned with the responses that will still arrive.
      if (bus.alu_flush) begin
         fpc_d      = flush_tgt;
         drop_cnt_d = out_cnt_q - {1'b0, bus.imem_rvld};
         fifo_cnt_d = 2'd0;
         fifo_rd_d  = 1'b0;
         fifo_wr_d  = 1'b0;
      end
   end

   // Control registers, asynchronously cleared
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         fpc_q      <= RESET_PC;
         out_cnt_q  <= 2'd0;
         drop_cnt_q <= 2'd0;
         fifo_cnt_q <= 2'd0;
         fifo_rd_q  <= 1'b0;
         fifo_wr_q  <= 1'b0;
         tag_rd_q   <= 1'b0;
         tag_wr_q   <= 1'b0;
      end else begin
         fpc_q      <= fpc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         fifo_rd_q  <= fifo_rd_d;
         fifo_wr_q  <= fifo_wr_d;
         tag_rd_q   <= tag_rd_d;
         tag_wr_q   <= tag_wr_d;
      end
   end

   // Data storage, qualified by the counters so it needs no reset
   always_ff @(posedge CLK) begin
      tag_q       <= tag_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
   end

endmodule
